// File: rtl/arf_latch_array_1r1w.sv
// 1-read/1-write latch-based register file: flopped write staging, low-phase row latches,
// two-stage registered read, optional even parity and a post-reset zero-fill sequencer.

module arf_ctech_clkgate (
  input  logic clk,
  input  logic en,
  output logic clkb
);
  logic en_l;

  // The enable is frozen while clk is low, so the gated low pulse cannot glitch.
  always_latch begin
    if (clk) en_l <= en;
  end

  assign clkb = clk | ~en_l;
endmodule

module arf_ctech_latch #(
  parameter int W = 1
) (
  input  logic         clkb,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // NOTE: storage has no reset. Latches use <= like flops, so every reader sees a settled value.
  always_latch begin
    if (!clkb) q <= d;
  end
endmodule

module arf_latch_array_1r1w #(
  parameter  int WIDTH   = 132,
  parameter  int DEPTH   = 192,
  parameter  int CTECH   = 1,
  parameter  int INIT_EN = 1,
  parameter  int PAR_EN  = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_vld,
  output logic             rd_perr,
  output logic             rd_oor,
  output logic             init_done
);
  localparam int          PW      = (PAR_EN != 0) ? 1 : 0;
  localparam int          SW      = WIDTH + PW;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t          state;
  logic [AW-1:0]   init_cnt;
  logic            stg_vld;
  logic [AW-1:0]   stg_addr;
  logic [SW-1:0]   stg_word;
  logic            rd_req_q;
  logic            rd_oor_q;
  logic [AW-1:0]   rd_addr_q;
  logic [SW-1:0]   mem [DEPTH];
  logic [SW-1:0]   in_word;
  logic [SW-1:0]   rd_word;
  logic            ready;
  logic            wr_ok;
  logic            rd_ok;
  logic            rd_in_range;
  logic            perr_calc;

  assign ready       = (state == S_READY);
  assign wr_ok       = wr_en && ready && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok       = rd_en && ready;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);

  if (PAR_EN != 0) begin : g_par
    assign in_word = {^wr_data, wr_data};
  end else begin : g_nopar
    assign in_word = wr_data;
  end

  // The address is flopped at edge N and the array is read at edge N+1, after the
  // low phase of cycle N has landed any write staged at edge N: that is the write-first bypass.
  assign rd_word   = mem[rd_addr_q];
  assign perr_calc = (PAR_EN != 0) && ((^rd_word[WIDTH-1:0]) != rd_word[SW-1]);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= (INIT_EN != 0) ? S_INIT : S_READY;
      init_cnt  <= '0;
      init_done <= 1'b0;
      stg_vld   <= 1'b0;
      stg_addr  <= '0;
      stg_word  <= '0;
      rd_req_q  <= 1'b0;
      rd_oor_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_data   <= '0;
      rd_vld    <= 1'b0;
      rd_perr   <= 1'b0;
      rd_oor    <= 1'b0;
    end else begin
      rd_vld   <= rd_req_q;
      rd_req_q <= rd_ok;
      rd_oor_q <= rd_ok && !rd_in_range;
      if (rd_ok && rd_in_range) rd_addr_q <= rd_addr;
      if (rd_req_q) begin
        rd_oor <= rd_oor_q;
        if (rd_oor_q) begin
          rd_data <= '0;
          rd_perr <= 1'b0;
        end else begin
          rd_data <= rd_word[WIDTH-1:0];
          rd_perr <= perr_calc;
        end
      end

      if (state == S_INIT) begin
        stg_vld  <= 1'b1;
        stg_addr <= init_cnt;
        stg_word <= '0;
        if (init_cnt == AW'(DEPTH - 1)) begin
          state     <= S_READY;
          init_done <= 1'b1;
        end else begin
          init_cnt <= init_cnt + 1'b1;
        end
      end else begin
        init_done <= 1'b1;
        stg_vld   <= wr_ok;
        if (wr_ok) begin
          stg_addr <= wr_addr;
          stg_word <= in_word;
        end
      end
    end
  end

  // The selected row is transparent only in the clk-low phase after its write was staged.
  if (CTECH != 0) begin : g_ctech
    for (genvar r = 0; r < DEPTH; r++) begin : g_row
      logic row_en;
      logic row_clkb;
      assign row_en = stg_vld && (stg_addr == AW'(r));
      arf_ctech_clkgate u_cg (.clk(clk), .en(row_en), .clkb(row_clkb));
      arf_ctech_latch #(.W(SW)) u_lat (.clkb(row_clkb), .d(stg_word), .q(mem[r]));
    end
  end else begin : g_beh
    always_latch begin
      if (!clk && stg_vld) mem[stg_addr] <= stg_word;
    end
  end
endmodule

// File: tb/tb_arf_latch_array_1r1w.sv
// Directed bench for arf_latch_array_1r1w: init sequencing, reads, bypass, out-of-range, parity.

module tb_arf_latch_array_1r1w;
  localparam int W  = 132;
  localparam int D  = 192;
  localparam int AW = 8;

  logic          clk;
  logic          rstb;
  logic          wr_en, rd_en;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [W-1:0]  wr_data, rd_data;
  logic          rd_vld, rd_perr, rd_oor, init_done;

  logic          b_wr_en, b_rd_en;
  logic [1:0]    b_wr_addr, b_rd_addr;
  logic [7:0]    b_wr_data, b_rd_data;
  logic          b_rd_vld, b_rd_perr, b_rd_oor, b_init_done;

  int errors = 0;
  int checks = 0;

  arf_latch_array_1r1w dut (
    .clk(clk), .rstb(rstb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_perr(rd_perr), .rd_oor(rd_oor),
    .init_done(init_done)
  );

  arf_latch_array_1r1w #(.WIDTH(8), .DEPTH(4), .CTECH(0), .INIT_EN(0), .PAR_EN(0)) dut_b (
    .clk(clk), .rstb(rstb),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_vld(b_rd_vld), .rd_perr(b_rd_perr), .rd_oor(b_rd_oor),
    .init_done(b_init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One read: request at the next edge, result visible one edge later.
  task automatic rd_chk(input string tag, input logic [AW-1:0] a, input logic [W-1:0] exp,
                        input logic exp_perr);
    rd_en   = 1'b1;
    rd_addr = a;
    step();
    rd_en = 1'b0;
    step();
    check({tag, "_vld"}, rd_vld, 1'b1);
    check({tag, "_data"}, rd_data, exp);
    check({tag, "_perr"}, rd_perr, exp_perr);
    check({tag, "_oor"}, rd_oor, 1'b0);
  endtask

  initial begin
    logic          saw_vld;
    logic [135:0]  pat_wide;
    logic [W-1:0]  pat_a5;

    pat_wide = {17{8'hA5}};
    pat_a5   = pat_wide[W-1:0];

    rstb = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr = '0;
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_rd_en = 1'b0; b_rd_addr = '0;
    repeat (2) step();

    check("rst_rd_vld", rd_vld, 1'b0);
    check("rst_rd_data", rd_data, '0);
    check("rst_rd_perr", rd_perr, 1'b0);
    check("rst_rd_oor", rd_oor, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_b_init_done", b_init_done, 1'b0);

    // Traffic during INIT must be ignored; reset lands at init row 100.
    wr_en = 1'b1; wr_addr = 8'd10; wr_data = 132'hDEAD;
    rd_en = 1'b1; rd_addr = 8'd10;
    rstb  = 1'b1;
    saw_vld = 1'b0;
    repeat (100) begin
      step();
      saw_vld |= rd_vld;
    end
    check("init_a_no_vld", saw_vld, 1'b0);
    check("init_a_not_done", init_done, 1'b0);

    rstb = 1'b0;
    step();
    check("midinit_rst_done", init_done, 1'b0);
    rstb = 1'b1;
    saw_vld = 1'b0;
    repeat (D - 1) begin
      step();
      saw_vld |= rd_vld;
    end
    check("init_b_done_191", init_done, 1'b0);
    step();
    saw_vld |= rd_vld;
    check("init_b_done_192", init_done, 1'b1);
    check("init_b_no_vld", saw_vld, 1'b0);
    check("b_init_done", b_init_done, 1'b1);
    wr_en = 1'b0;
    rd_en = 1'b0;

    // Every entry reads back zero after the zero-fill (entry 10 included).
    for (int i = 0; i <= D; i++) begin
      if (i < D) begin
        rd_en   = 1'b1;
        rd_addr = AW'(i);
      end else begin
        rd_en = 1'b0;
      end
      step();
      if (i == 0) begin
        check("init_last_edge_vld", rd_vld, 1'b0);
      end else begin
        check($sformatf("zero_vld_%0d", i - 1), rd_vld, 1'b1);
        check($sformatf("zero_data_%0d", i - 1), rd_data, '0);
        check($sformatf("zero_perr_%0d", i - 1), rd_perr, 1'b0);
      end
    end

    // Write then read on the next cycle.
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = pat_a5;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 8'd5;
    step();
    check("t2_idle_vld", rd_vld, 1'b0);
    rd_en = 1'b0;
    step();
    check("t2_vld", rd_vld, 1'b1);
    check("t2_data", rd_data, pat_a5);
    check("t2_perr", rd_perr, 1'b0);
    step();
    check("t2_hold_vld", rd_vld, 1'b0);
    check("t2_hold_data", rd_data, pat_a5);

    // Same-cycle write and read of one address returns the new data.
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 132'h1234;
    rd_en = 1'b1; rd_addr = 8'd7;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    step();
    check("t3_byp_vld", rd_vld, 1'b1);
    check("t3_byp_data", rd_data, 132'h1234);

    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 132'h1;
    step();
    wr_data = 132'h2;
    step();
    wr_en = 1'b0;
    rd_chk("t3_last_wins", 8'd7, 132'h2, 1'b0);

    wr_en = 1'b1; wr_addr = 8'd8; wr_data = 132'hBEEF;
    rd_en = 1'b1; rd_addr = 8'd5;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    step();
    check("t3_split_data", rd_data, pat_a5);
    rd_chk("t3_rd8", 8'd8, 132'hBEEF, 1'b0);

    // Out-of-range read and write.
    rd_en = 1'b1; rd_addr = 8'd200;
    step();
    rd_en = 1'b0;
    step();
    check("t4_oor_vld", rd_vld, 1'b1);
    check("t4_oor_flag", rd_oor, 1'b1);
    check("t4_oor_data", rd_data, '0);
    check("t4_oor_perr", rd_perr, 1'b0);

    wr_en = 1'b1; wr_addr = 8'd200; wr_data = {W{1'b1}};
    step();
    wr_en = 1'b0;
    rd_chk("t4_keep8", 8'd8, 132'hBEEF, 1'b0);
    rd_chk("t4_keep72", 8'd72, '0, 1'b0);
    rd_chk("t4_keep5", 8'd5, pat_a5, 1'b0);
    rd_chk("t4_keep191", 8'd191, '0, 1'b0);

    // Flip the stored parity bit of entry 3 (data 0): parity error on read.
    dut.g_ctech.g_row[3].u_lat.q = {1'b1, 132'h0};
    rd_chk("t5_flip", 8'd3, '0, 1'b1);
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = 132'h1;
    step();
    wr_en = 1'b0;
    rd_chk("t5_rewrite", 8'd3, 132'h1, 1'b0);

    // Parity-less, behavioural, no-init instance.
    b_wr_en = 1'b1; b_wr_addr = 2'd2; b_wr_data = 8'h07;
    step();
    b_wr_en = 1'b0;
    b_rd_en = 1'b1; b_rd_addr = 2'd2;
    step();
    b_rd_en = 1'b0;
    step();
    check("b_vld", b_rd_vld, 1'b1);
    check("b_data", b_rd_data, 8'h07);
    check("b_perr", b_rd_perr, 1'b0);

    b_wr_en = 1'b1; b_wr_addr = 2'd1; b_wr_data = 8'h3C;
    b_rd_en = 1'b1; b_rd_addr = 2'd1;
    step();
    b_wr_en = 1'b0;
    b_rd_en = 1'b0;
    step();
    check("b_byp_vld", b_rd_vld, 1'b1);
    check("b_byp_data", b_rd_data, 8'h3C);
    check("b_byp_oor", b_rd_oor, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
